// File: rtl/inst_fetch_pkg.sv
// Shared widths, encodings and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned RegAddrBus = 32;
  localparam int unsigned InstBus    = 32;

  typedef logic [RegAddrBus-1:0] addr_t;
  typedef logic [InstBus-1:0]    inst_t;

  localparam inst_t ZeroWord = '0;
  localparam logic  ChipEna  = 1'b1;
  localparam logic  ChipDisa = 1'b0;
  localparam addr_t PcIncr   = 32'd4;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus: instruction ROM port plus the IF/ID register outputs.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic  rom_ce;
  addr_t rom_addr;
  inst_t rom_inst;
  addr_t id_pc;
  inst_t id_inst;
  logic  id_valid;
  logic  id_adel;

  modport master (
    output rom_ce, rom_addr, id_pc, id_inst, id_valid, id_adel,
    input  rom_inst
  );

  modport slave (
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid, id_adel,
    output rom_inst
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter, ROM chip enable and the one-entry pending-branch register.
module pc_reg
  import inst_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  branch_flag_i,
  input  addr_t branch_target_i,
  output addr_t pc_o,
  output logic  ce_o
);

  addr_t pc_q, pc_d;
  logic  ce_q;
  logic  pend_q, pend_d;
  addr_t pend_tgt_q, pend_tgt_d;

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (ce_q == ChipDisa) begin
      pc_d   = RESET_PC;
      pend_d = 1'b0;
    end else if (stall) begin
      // A branch resolved during a stall is parked; the newest one wins.
      if (branch_flag_i) begin
        pend_d     = 1'b1;
        pend_tgt_d = branch_target_i;
      end
    end else begin
      pend_d = 1'b0;
      if (branch_flag_i) begin
        pc_d = branch_target_i;
      end else if (pend_q) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = pc_q + PcIncr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q       <= ChipDisa;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      ce_q       <= ChipEna;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_o = pc_q;
  assign ce_o = ce_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, direct ROM access and the IF/ID register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_flag_i,
  input  addr_t               branch_target_i,
  inst_fetch_if.master        bus
);

  addr_t pc;
  logic  ce;

  addr_t id_pc_q, id_pc_d;
  inst_t id_inst_q, id_inst_d;
  logic  id_valid_q, id_valid_d;
  logic  id_adel_q, id_adel_d;
  logic  misaligned;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc),
    .ce_o            (ce)
  );

  assign misaligned = |pc[1:0];

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    if (flush) begin
      id_pc_d    = '0;
      id_inst_d  = ZeroWord;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (!stall) begin
      // Misaligned fetches hand ID a nop and raise the address-error flag.
      id_pc_d    = pc;
      id_inst_d  = misaligned ? ZeroWord : bus.rom_inst;
      id_valid_d = (ce == ChipEna);
      id_adel_d  = misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_q    <= '0;
      id_inst_q  <= ZeroWord;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

  assign bus.rom_ce   = ce;
  assign bus.rom_addr = pc;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.id_valid = id_valid_q;
  assign bus.id_adel  = id_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: default reset PC plus a wrap-around reset PC instance.
module tb_inst_fetch;

  logic        clk;
  logic        rst0, stall0, flush0, br0;
  logic [31:0] tgt0;
  logic        rst1, stall1, flush1, br1;
  logic [31:0] tgt1;

  int checks;
  int failures;

  inst_fetch_if if0 ();
  inst_fetch_if if1 ();

  // ROM word i holds 32'h1000_0000 + i.
  assign if0.rom_inst = 32'h1000_0000 + (if0.rom_addr >> 2);
  assign if1.rom_inst = 32'h1000_0000 + (if1.rom_addr >> 2);

  inst_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut0 (
    .clk             (clk),
    .rst             (rst0),
    .stall           (stall0),
    .flush           (flush0),
    .branch_flag_i   (br0),
    .branch_target_i (tgt0),
    .bus             (if0)
  );

  inst_fetch #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut1 (
    .clk             (clk),
    .rst             (rst1),
    .stall           (stall1),
    .flush           (flush1),
    .branch_flag_i   (br1),
    .branch_target_i (tgt1),
    .bus             (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst0 = 1'b1; stall0 = 1'b0; flush0 = 1'b0; br0 = 1'b0; tgt0 = '0;
    rst1 = 1'b1; stall1 = 1'b0; flush1 = 1'b0; br1 = 1'b0; tgt1 = '0;

    step();
    step();
    check("rst_ce", {31'b0, if0.rom_ce}, 32'h0);
    check("rst_addr", if0.rom_addr, 32'h0);
    check("rst_id_pc", if0.id_pc, 32'h0);
    check("rst_id_inst", if0.id_inst, 32'h0);
    check("rst_id_valid", {31'b0, if0.id_valid}, 32'h0);
    check("rst_id_adel", {31'b0, if0.id_adel}, 32'h0);

    rst0 = 1'b0;
    step();
    check("rel1_ce", {31'b0, if0.rom_ce}, 32'h1);
    check("rel1_addr", if0.rom_addr, 32'h0);
    check("rel1_id_valid", {31'b0, if0.id_valid}, 32'h0);
    step();
    check("rel2_addr", if0.rom_addr, 32'h4);
    check("rel2_id_inst", if0.id_inst, 32'h1000_0000);
    check("rel2_id_valid", {31'b0, if0.id_valid}, 32'h1);
    check("rel2_id_pc", if0.id_pc, 32'h0);
    step();
    check("rel3_addr", if0.rom_addr, 32'h8);
    check("rel3_id_inst", if0.id_inst, 32'h1000_0001);

    // Unstalled branch to 0x40.
    br0 = 1'b1; tgt0 = 32'h40;
    step();
    br0 = 1'b0;
    check("br_addr", if0.rom_addr, 32'h40);
    check("br_id_pc_old", if0.id_pc, 32'h8);
    step();
    check("br_id_pc", if0.id_pc, 32'h40);
    check("br_id_inst", if0.id_inst, 32'h1000_0010);
    check("br_next_addr", if0.rom_addr, 32'h44);

    // Three stall cycles with a branch pulsed in the second.
    stall0 = 1'b1;
    step();
    check("st1_addr", if0.rom_addr, 32'h44);
    check("st1_id_pc", if0.id_pc, 32'h40);
    br0 = 1'b1; tgt0 = 32'h80;
    step();
    br0 = 1'b0;
    check("st2_addr", if0.rom_addr, 32'h44);
    check("st2_id_inst", if0.id_inst, 32'h1000_0010);
    step();
    check("st3_addr", if0.rom_addr, 32'h44);
    stall0 = 1'b0;
    step();
    check("pend_addr", if0.rom_addr, 32'h80);
    check("pend_id_pc", if0.id_pc, 32'h44);
    step();
    check("pend_next_addr", if0.rom_addr, 32'h84);
    check("pend_next_id_pc", if0.id_pc, 32'h80);

    // Flush together with stall.
    flush0 = 1'b1; stall0 = 1'b1;
    step();
    flush0 = 1'b0; stall0 = 1'b0;
    check("fl_id_valid", {31'b0, if0.id_valid}, 32'h0);
    check("fl_id_inst", if0.id_inst, 32'h0);
    check("fl_id_pc", if0.id_pc, 32'h0);
    check("fl_addr", if0.rom_addr, 32'h84);
    step();
    check("fl_after_addr", if0.rom_addr, 32'h88);
    check("fl_after_valid", {31'b0, if0.id_valid}, 32'h1);

    // Misaligned branch target.
    br0 = 1'b1; tgt0 = 32'h42;
    step();
    br0 = 1'b0;
    check("mis_addr", if0.rom_addr, 32'h42);
    step();
    check("mis_adel", {31'b0, if0.id_adel}, 32'h1);
    check("mis_id_inst", if0.id_inst, 32'h0);
    check("mis_id_pc", if0.id_pc, 32'h42);
    check("mis_next_addr", if0.rom_addr, 32'h46);
    step();
    check("mis2_addr", if0.rom_addr, 32'h4A);

    // Two branches while stalled: the newer target wins.
    stall0 = 1'b1; br0 = 1'b1; tgt0 = 32'h100;
    step();
    tgt0 = 32'h200;
    step();
    stall0 = 1'b0; br0 = 1'b0;
    step();
    check("newest_addr", if0.rom_addr, 32'h200);
    step();
    check("aligned_adel", {31'b0, if0.id_adel}, 32'h0);
    check("aligned_inst", if0.id_inst, 32'h1000_0080);

    // Wrap-around instance.
    check("w_rst_addr", if1.rom_addr, 32'hFFFF_FFFC);
    check("w_rst_ce", {31'b0, if1.rom_ce}, 32'h0);
    rst1 = 1'b0;
    step();
    check("w1_addr", if1.rom_addr, 32'hFFFF_FFFC);
    check("w1_ce", {31'b0, if1.rom_ce}, 32'h1);
    step();
    check("w2_addr", if1.rom_addr, 32'h0);
    check("w2_id_pc", if1.id_pc, 32'hFFFF_FFFC);
    check("w2_id_inst", if1.id_inst, 32'h4FFF_FFFF);

    // Asynchronous reset while stalled with a branch pending.
    stall1 = 1'b1; br1 = 1'b1; tgt1 = 32'h300;
    step();
    br1 = 1'b0;
    #2;
    rst1 = 1'b1;
    #1;
    check("ar_ce", {31'b0, if1.rom_ce}, 32'h0);
    check("ar_addr", if1.rom_addr, 32'hFFFF_FFFC);
    check("ar_id_pc", if1.id_pc, 32'h0);
    check("ar_id_inst", if1.id_inst, 32'h0);
    check("ar_id_valid", {31'b0, if1.id_valid}, 32'h0);
    check("ar_id_adel", {31'b0, if1.id_adel}, 32'h0);
    step();
    rst1 = 1'b0; stall1 = 1'b0;
    step();
    check("ar_rel1_addr", if1.rom_addr, 32'hFFFF_FFFC);
    step();
    check("ar_rel2_addr", if1.rom_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port stall, input, 1, from pipeline control: hold PC and the IF/ID register.
REQ-005 SHALL have port flush, input, 1, from pipeline control: kill the IF/ID contents.
REQ-006 SHALL have port branch_flag_i, input, 1, a taken branch/jump resolved in ID.
REQ-007 SHALL have port branch_target_i, input, 32, the redirect address.
REQ-008 SHALL have port rom_ce, output, 1, instruction ROM chip enable (`ChipEna`/`ChipDisa`).
REQ-009 SHALL have port rom_addr, output, 32 (`RegAddrBus`), the byte address of the current fetch, equal to the PC.
REQ-010 SHALL have port rom_inst_i, input, 32 (`InstBus`), the ROM data, combinational from rom_addr in the same cycle.
REQ-011 SHALL have port id_pc, output, 32, the PC of the instruction presented to ID.
REQ-012 SHALL have port id_inst, output, 32, the instruction presented to ID.
REQ-013 SHALL have port id_valid, output, 1, qualifying id_pc and id_inst.
REQ-014 SHALL have port id_adel, output, 1, flagging a misaligned fetch address for the instruction in ID.

Function
REQ-015 rom_ce SHALL be a register: `ChipDisa` in reset, then `ChipEna` from the first rising edge after rst deasserts.
REQ-016 While rom_ce is `ChipDisa`, the PC SHALL be held at RESET_PC, so the first enabled fetch reads RESET_PC.
REQ-017 The PC update priority SHALL be: ce disabled -> RESET_PC; stall -> hold; pending branch or branch_flag_i -> target; otherwise PC+4.
REQ-018 PC+4 SHALL use modulo-2^32 arithmetic, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-019 branch_flag_i asserted while stall=1 SHALL be latched with its target into a one-entry pending-branch register, and SHALL NOT be lost.
REQ-020 The pending branch SHALL be applied on the first non-stalled cycle and then cleared.
REQ-021 A new branch_flag_i arriving while a branch is pending SHALL overwrite the pending target (the newest branch wins).
REQ-022 The IF/ID register SHALL update with the following priority: flush -> id_pc=0, id_inst=`ZeroWord`, id_valid=0, id_adel=0; else stall -> hold; else capture PC, rom_inst_i, id_valid=(rom_ce==`ChipEna`), and id_adel=|PC[1:0].
REQ-023 Flush and stall asserted together SHALL flush the IF/ID register while the PC follows REQ-017 (held).
REQ-024 When PC[1:0]!=0, the captured id_inst SHALL be forced to `ZeroWord` (nop) and id_adel=1.
REQ-025 A misaligned PC SHALL still advance by +4 unless redirected.
REQ-026 Fetch-to-ID latency SHALL be exactly one cycle: the instruction at rom_addr in cycle N appears on id_inst in cycle N+1 when unstalled.
REQ-027 Branch redirect latency SHALL be one cycle: branch_flag_i in cycle N (unstalled) -> rom_addr=target in cycle N+1.

Reset
REQ-028 rst=1 SHALL asynchronously set: PC=RESET_PC, rom_ce=`ChipDisa`, pending branch cleared, id_pc=0, id_inst=`ZeroWord`, id_valid=0, id_adel=0.
REQ-029 Reset asserted mid-stall or with a branch pending SHALL discard all pending state; fetch restarts at RESET_PC per REQ-015/016.

Structure
REQ-030 The width macros (`RegAddrBus`, `InstBus`), `ZeroWord`, `ChipEna`/`ChipDisa`, and the PC increment constant SHALL live in the shared define.v.
REQ-031 The PC, rom_ce, and pending-branch logic SHALL be a sub-module pc_reg.
REQ-032 The IF/ID register SHALL remain in inst_fetch.
REQ-033 The block SHALL connect directly to the instruction ROM via rom_ce/rom_addr/rom_inst_i with no extra glue.

Verification
REQ-034 Reset release with a ROM model holding word i = 32'h1000_0000+i -> rom_addr sequence 0,0,4,8; id_inst = 32'h1000_0000 one cycle after rom_addr=0 with rom_ce=`ChipEna`; id_valid=1.
REQ-035 branch_flag_i=1, target=32'h0000_0040, unstalled -> next rom_addr=32'h40; the following cycle id_pc=32'h40.
REQ-036 stall=1 for 3 cycles with branch_flag_i pulsed (target 32'h80) in the second stall cycle -> PC and IF/ID held; first cycle after stall rom_addr=32'h80.
REQ-037 flush=1 together with stall=1 -> next cycle id_valid=0, id_inst=0, PC unchanged.
REQ-038 Branch to 32'h0000_0042 -> id_adel=1, id_inst=0; next rom_addr=32'h46.
REQ-039 RESET_PC=32'hFFFF_FFFC, run 2 fetches -> rom_addr=32'hFFFF_FFFC then 32'h0; rst asserted mid-stall -> outputs match REQ-028 immediately, without waiting for a clock edge.
